pulse_train_gen: RTL and testbench

PULSE_TRAIN_GEN -- requirements
Module: pulse_train_gen

---
 rtl/pulse_train_gen_if.sv | 29 ++
 rtl/pulse_train_gen.sv | 139 +++++++++++++
 tb/tb_pulse_train_gen.sv | 224 ++++++++++++++++++++++
 3 files changed

// File: rtl/pulse_train_gen_if.sv
// Pulse-train generator request/status bundle.
//   master: drives start, high_cycles, low_cycles, num_pulses, abort; observes status
//   slave : the generator; observes the request fields and drives z, busy, done,
//           aborted, pulses_sent
interface pulse_train_gen_if #(
  parameter int unsigned CW = 8,
  parameter int unsigned NW = 4
) ();
  logic          start;
  logic [CW-1:0] high_cycles;
  logic [CW-1:0] low_cycles;
  logic [NW-1:0] num_pulses;
  logic          abort;
  logic          z;
  logic          busy;
  logic          done;
  logic          aborted;
  logic [NW-1:0] pulses_sent;

  modport master (
    output start, high_cycles, low_cycles, num_pulses, abort,
    input  z, busy, done, aborted, pulses_sent
  );

  modport slave (
    input  start, high_cycles, low_cycles, num_pulses, abort,
    output z, busy, done, aborted, pulses_sent
  );
endinterface

// File: rtl/pulse_train_gen.sv
// Programmable pulse-train generator: emits num_pulses high phases of
// high_cycles each, separated by low gaps of low_cycles, with abort and
// single-cycle completion/abort indications.
//   clk : system clock, all updates on posedge
//   rst : synchronous active-high reset
//   bus : pulse_train_gen_if slave (request fields in, z/busy/done/aborted/pulses_sent out)
module pulse_train_gen #(
  parameter int unsigned CW = 8,
  parameter int unsigned NW = 4
) (
  input  logic             clk,
  input  logic             rst,
  pulse_train_gen_if.slave bus
);

  typedef enum logic [2:0] {
    IDLE = 3'd0,
    HIGH = 3'd1,
    LOW  = 3'd2,
    FIN  = 3'd3,
    ABT  = 3'd4
  } state_e;

  state_e        state_q, state_d;
  logic [CW-1:0] h_q, h_d;
  logic [CW-1:0] l_q, l_d;
  logic [NW-1:0] n_q, n_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic [NW-1:0] sent_q, sent_d;
  logic          z_q, z_d;
  logic          busy_q, busy_d;
  logic          done_q, done_d;
  logic          abt_q, abt_d;
  logic          last_pulse_c;

  // Compare one bit wider so sent+1 cannot wrap at full-scale N.
  assign last_pulse_c = (({1'b0, sent_q} + (NW+1)'(1)) == {1'b0, n_q});

  // State register, latched fields, counters and registered outputs.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      h_q     <= '0;
      l_q     <= '0;
      n_q     <= '0;
      cnt_q   <= '0;
      sent_q  <= '0;
      z_q     <= 1'b0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
      abt_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      h_q     <= h_d;
      l_q     <= l_d;
      n_q     <= n_d;
      cnt_q   <= cnt_d;
      sent_q  <= sent_d;
      z_q     <= z_d;
      busy_q  <= busy_d;
      done_q  <= done_d;
      abt_q   <= abt_d;
    end
  end

  // Next-state, counter and output decode.
  always_comb begin
    state_d = state_q;
    h_d     = h_q;
    l_d     = l_q;
    n_d     = n_q;
    cnt_d   = cnt_q;
    sent_d  = sent_q;

    case (state_q)
      IDLE, FIN, ABT: begin
        state_d = IDLE;
        if (bus.start) begin
          h_d    = (bus.high_cycles == '0) ? CW'(1) : bus.high_cycles;
          l_d    = bus.low_cycles;
          n_d    = bus.num_pulses;
          sent_d = '0;
          if (bus.num_pulses == '0) begin
            state_d = FIN;
          end else begin
            state_d = HIGH;
            cnt_d   = h_d - CW'(1);
          end
        end
      end

      HIGH: begin
        if (bus.abort) begin
          state_d = ABT;
        end else if (cnt_q == '0) begin
          sent_d = sent_q + NW'(1);
          if (last_pulse_c) begin
            state_d = FIN;
          end else if (l_q == '0) begin
            // Zero gap: pulses merge into one continuous high level.
            state_d = HIGH;
            cnt_d   = h_q - CW'(1);
          end else begin
            state_d = LOW;
            cnt_d   = l_q - CW'(1);
          end
        end else begin
          cnt_d = cnt_q - CW'(1);
        end
      end

      LOW: begin
        if (bus.abort) begin
          state_d = ABT;
        end else if (cnt_q == '0) begin
          state_d = HIGH;
          cnt_d   = h_q - CW'(1);
        end else begin
          cnt_d = cnt_q - CW'(1);
        end
      end

      default: state_d = IDLE;
    endcase

    // Outputs are registered copies of the next-state decode.
    z_d    = (state_d == HIGH);
    busy_d = (state_d == HIGH) || (state_d == LOW);
    done_d = (state_d == FIN);
    abt_d  = (state_d == ABT);
  end

  assign bus.z           = z_q;
  assign bus.busy        = busy_q;
  assign bus.done        = done_q;
  assign bus.aborted     = abt_q;
  assign bus.pulses_sent = sent_q;

endmodule

// File: tb/tb_pulse_train_gen.sv
module tb_pulse_train_gen;
  localparam int unsigned CW = 8;
  localparam int unsigned NW = 4;

  logic clk;
  logic rst;
  int   checks;
  int   errors;

  pulse_train_gen_if #(.CW(CW), .NW(NW)) bus ();

  pulse_train_gen #(.CW(CW), .NW(NW)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      if (errors <= 40)
        $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Reference model: a train is expanded into a list of per-cycle expected outputs.
  typedef struct {
    logic z;
    logic busy;
    logic done;
    logic ab;
    int   sent;
  } exp_t;

  exp_t cur;
  exp_t q[$];

  function automatic exp_t mk(logic z, logic b, logic d, logic a, int s);
    exp_t e;
    e.z = z; e.busy = b; e.done = d; e.ab = a; e.sent = s;
    return e;
  endfunction

  function automatic void build(int h, int l, int n);
    q.delete();
    if (h == 0) h = 1;
    for (int i = 0; i < n; i++) begin
      for (int c = 0; c < h; c++) q.push_back(mk(1'b1, 1'b1, 1'b0, 1'b0, i));
      if (i < n - 1)
        for (int c = 0; c < l; c++) q.push_back(mk(1'b0, 1'b1, 1'b0, 1'b0, i + 1));
    end
    q.push_back(mk(1'b0, 1'b0, 1'b1, 1'b0, n));
  endfunction

  initial cur = mk(1'b0, 1'b0, 1'b0, 1'b0, 0);

  always @(posedge clk) begin
    if (rst) begin
      q.delete();
      cur = mk(1'b0, 1'b0, 1'b0, 1'b0, 0);
    end else if (cur.busy && bus.abort) begin
      q.delete();
      cur = mk(1'b0, 1'b0, 1'b0, 1'b1, cur.sent);
    end else if (!cur.busy && bus.start) begin
      build(int'(bus.high_cycles), int'(bus.low_cycles), int'(bus.num_pulses));
      cur = q.pop_front();
    end else if (q.size() > 0) begin
      cur = q.pop_front();
    end else begin
      cur = mk(1'b0, 1'b0, 1'b0, 1'b0, cur.sent);
    end
  end

  // Per-cycle comparison against the model.
  always @(negedge clk) begin
    check("m_z", 64'(bus.z), 64'(cur.z));
    check("m_busy", 64'(bus.busy), 64'(cur.busy));
    check("m_done", 64'(bus.done), 64'(cur.done));
    check("m_aborted", 64'(bus.aborted), 64'(cur.ab));
    check("m_pulses_sent", 64'(bus.pulses_sent), 64'(cur.sent));
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Directed run: start/abort/rst asserted in the cycles flagged by the masks.
  task automatic run(input int h, input int l, input int n,
                     input logic [63:0] smask, input logic [63:0] amask,
                     input logic [63:0] rmask, input int ncyc,
                     output logic [63:0] zr, output logic [63:0] br,
                     output logic [63:0] dr, output logic [63:0] ar,
                     output int zcnt, output int rises, output int sent_end);
    logic zp;
    zr = '0; br = '0; dr = '0; ar = '0;
    zcnt = 0; rises = 0; zp = 1'b0;
    bus.high_cycles = CW'(h);
    bus.low_cycles  = CW'(l);
    bus.num_pulses  = NW'(n);
    for (int c = 0; c < ncyc; c++) begin
      bus.start = (c < 64) ? smask[6'(c)] : 1'b0;
      bus.abort = (c < 64) ? amask[6'(c)] : 1'b0;
      rst       = (c < 64) ? rmask[6'(c)] : 1'b0;
      @(negedge clk);
      if (c < 64) begin
        zr[6'(c)] = bus.z;
        br[6'(c)] = bus.busy;
        dr[6'(c)] = bus.done;
        ar[6'(c)] = bus.aborted;
      end
      if (bus.z === 1'b1) zcnt++;
      if (bus.z === 1'b1 && !zp) rises++;
      zp = bus.z;
      tick();
    end
    bus.start = 1'b0;
    bus.abort = 1'b0;
    rst       = 1'b0;
    for (int k = 0; k < 10000 && bus.busy !== 1'b0; k++) tick();
    if (bus.busy !== 1'b0) check("drain_timeout", 64'(bus.busy), 64'd0);
    sent_end = int'(bus.pulses_sent);
    tick();
  endtask

  logic [63:0] zr, br, dr, ar;
  int          zc, rs, se;

  initial begin
    #2000000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    checks = 0;
    errors = 0;
    rst = 1'b1;
    bus.start = 1'b0;
    bus.abort = 1'b0;
    bus.high_cycles = '0;
    bus.low_cycles  = '0;
    bus.num_pulses  = '0;
    repeat (3) @(posedge clk);
    #1;
    rst = 1'b0;
    @(negedge clk);
    check("reset_z", 64'(bus.z), 64'd0);
    check("reset_busy", 64'(bus.busy), 64'd0);
    check("reset_pulses_sent", 64'(bus.pulses_sent), 64'd0);
    tick();

    // H=2 L=3 N=3
    run(2, 3, 3, 64'h1, 64'h0, 64'h0, 15, zr, br, dr, ar, zc, rs, se);
    check("basic_z", zr & 64'h7FFF, 64'h18C6);
    check("basic_busy", br & 64'h7FFF, 64'h1FFE);
    check("basic_done", dr & 64'h7FFF, 64'h2000);
    check("basic_sent", 64'(se), 64'd3);

    // N=0
    run(3, 3, 0, 64'h1, 64'h0, 64'h0, 4, zr, br, dr, ar, zc, rs, se);
    check("n0_z", zr & 64'hF, 64'h0);
    check("n0_busy", br & 64'hF, 64'h0);
    check("n0_done", dr & 64'hF, 64'h2);

    // high_cycles=0, L=0, N=2: merged pulses
    run(0, 0, 2, 64'h1, 64'h0, 64'h0, 5, zr, br, dr, ar, zc, rs, se);
    check("merge_z", zr & 64'h1F, 64'h6);
    check("merge_done", dr & 64'h1F, 64'h8);

    // abort in LOW
    run(4, 4, 5, 64'h1, 64'h40, 64'h0, 12, zr, br, dr, ar, zc, rs, se);
    check("abort_z", zr & 64'hFFF, 64'h1E);
    check("abort_aborted", ar & 64'hFFF, 64'h80);
    check("abort_done", dr & 64'hFFF, 64'h0);
    check("abort_sent", 64'(se), 64'd1);

    // starts during HIGH/LOW ignored, start on FIN restarts
    run(3, 3, 2, 64'h425, 64'h0, 64'h0, 14, zr, br, dr, ar, zc, rs, se);
    check("restart_z", zr & 64'h3FFF, 64'h3B8E);
    check("restart_done", dr & 64'h7FF, 64'h400);

    // rst mid-train, then power-up-like restart
    run(2, 2, 4, 64'h1, 64'h0, 64'h40, 9, zr, br, dr, ar, zc, rs, se);
    check("rst_z", zr & 64'h1FF, 64'h66);
    check("rst_busy", br & 64'h1FF, 64'h7E);
    check("rst_sent", 64'(se), 64'd0);
    run(2, 3, 3, 64'h1, 64'h0, 64'h0, 15, zr, br, dr, ar, zc, rs, se);
    check("post_rst_z", zr & 64'h7FFF, 64'h18C6);
    check("post_rst_done", dr & 64'h7FFF, 64'h2000);

    // full-scale H and N
    run(255, 1, 15, 64'h1, 64'h0, 64'h0, 3845, zr, br, dr, ar, zc, rs, se);
    check("full_z_head", zr, 64'hFFFF_FFFF_FFFF_FFFE);
    check("full_zcount", 64'(zc), 64'd3825);
    check("full_rises", 64'(rs), 64'd15);
    check("full_sent", 64'(se), 64'd15);

    // randomized traffic
    for (int c = 0; c < 4000; c++) begin
      bus.start = ($urandom_range(0, 3) == 0);
      bus.high_cycles = ($urandom_range(0, 9) == 0) ? CW'($urandom_range(0, 255))
                                                    : CW'($urandom_range(0, 4));
      bus.low_cycles  = ($urandom_range(0, 9) == 0) ? CW'($urandom_range(0, 40))
                                                    : CW'($urandom_range(0, 3));
      bus.num_pulses  = ($urandom_range(0, 9) == 0) ? NW'(15) : NW'($urandom_range(0, 5));
      bus.abort = ($urandom_range(0, 39) == 0);
      rst       = ($urandom_range(0, 299) == 0);
      tick();
    end
    bus.start = 1'b0;
    bus.abort = 1'b0;
    rst       = 1'b0;
    repeat (3) tick();

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
